// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op encodings and address-width derivation for the stack engine
package stack_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_PUSH = 3'd1,
      OP_POP  = 3'd2,
      OP_PEEK = 3'd3,
      OP_CALL = 3'd4,
      OP_RET  = 3'd5
   } op_e;

   localparam int OP_W = 3;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/stack_engine_if.sv
// rtl/stack_engine_if.sv - op/data bus between a stack client and the stack engine
interface stack_engine_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 10,
   parameter int AW     = 11
);
   logic              en;
   logic [2:0]        op;
   logic [DATA_W-1:0] din;
   logic [PC_W-1:0]   pcIn;
   logic              clrErr;
   logic [DATA_W-1:0] dout;
   logic              doutValid;
   logic [PC_W-1:0]   pcOut;
   logic              pcLoad;
   logic              full;
   logic              empty;
   logic [AW:0]       level;
   logic              ovf;
   logic              unf;

   modport master (
      output en, op, din, pcIn, clrErr,
      input  dout, doutValid, pcOut, pcLoad, full, empty, level, ovf, unf
   );

   modport slave (
      input  en, op, din, pcIn, clrErr,
      output dout, doutValid, pcOut, pcLoad, full, empty, level, ovf, unf
   );
endinterface

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - DEPTH x DATA_W storage, one synchronous write and one synchronous read port
module stack_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2048,
   parameter int AW     = 11
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end
endmodule

// File: rtl/stack_engine.sv
// rtl/stack_engine.sv - hardware stack with PUSH/POP/PEEK/CALL/RET and sticky freeze-on-error flags
module stack_engine
   import stack_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2048,
   parameter int PC_W   = 10
) (
   input logic           clk,
   input logic           rst,
   stack_engine_if.slave bus
);
   localparam int AW = addr_w(DEPTH);
   typedef logic [AW:0] lvl_t;

   lvl_t              level_q;
   logic              ovf_q, unf_q;
   logic              dv_q, pl_q;
   logic [DATA_W-1:0] dout_hold;
   logic [PC_W-1:0]   pc_hold;
   logic [DATA_W-1:0] rdata;

   logic              full_c, empty_c, frozen, act;
   logic              is_wr, is_rd, wr_ok, rd_ok;
   logic              ovf_set, unf_set;
   logic [PC_W-1:0]   pc_next;
   logic [DATA_W-1:0] wdata;
   logic [AW-1:0]     waddr, raddr;
   logic [DATA_W-1:0] dout_c;
   logic [PC_W-1:0]   pcout_c;

   always_comb begin
      full_c  = (level_q == lvl_t'(DEPTH));
      empty_c = (level_q == '0);
      frozen  = ovf_q | unf_q;
      act     = bus.en & ~frozen;
      is_wr   = (bus.op == OP_PUSH) || (bus.op == OP_CALL);
      is_rd   = (bus.op == OP_POP) || (bus.op == OP_PEEK) || (bus.op == OP_RET);
      wr_ok   = act & is_wr & ~full_c;
      rd_ok   = act & is_rd & ~empty_c;
      // clrErr wins over a flag-setting op in the same cycle
      ovf_set = act & is_wr & full_c & ~bus.clrErr;
      unf_set = act & is_rd & empty_c & ~bus.clrErr;
      pc_next = bus.pcIn + PC_W'(1);
      wdata   = (bus.op == OP_CALL) ? DATA_W'(pc_next) : bus.din;
      waddr   = level_q[AW-1:0];
      raddr   = level_q[AW-1:0] - AW'(1);
   end

   stack_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok & ~rst),
      .waddr (waddr),
      .wdata (wdata),
      .re    (rd_ok & ~rst),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q   <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         dv_q      <= 1'b0;
         pl_q      <= 1'b0;
         dout_hold <= '0;
         pc_hold   <= '0;
      end else begin
         dout_hold <= dout_c;
         pc_hold   <= pcout_c;
         dv_q      <= rd_ok & (bus.op != OP_RET);
         pl_q      <= rd_ok & (bus.op == OP_RET);
         if (wr_ok) begin
            level_q <= level_q + lvl_t'(1);
         end else if (rd_ok && bus.op != OP_PEEK) begin
            level_q <= level_q - lvl_t'(1);
         end
         if (bus.clrErr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end else begin
            if (ovf_set) ovf_q <= 1'b1;
            if (unf_set) unf_q <= 1'b1;
         end
      end
   end

   // RAM output is live only in the pulse cycle; otherwise the held value is shown
   always_comb begin
      dout_c  = dv_q ? rdata : dout_hold;
      pcout_c = pl_q ? rdata[PC_W-1:0] : pc_hold;
   end

   assign bus.dout      = dout_c;
   assign bus.doutValid = dv_q;
   assign bus.pcOut     = pcout_c;
   assign bus.pcLoad    = pl_q;
   assign bus.full      = full_c;
   assign bus.empty     = empty_c;
   assign bus.level     = level_q;
   assign bus.ovf       = ovf_q;
   assign bus.unf       = unf_q;
endmodule

// File: tb/tb_stack_engine.sv
// tb/tb_stack_engine.sv - directed and random checks of stack_engine against a queue-based model
module tb_stack_engine;
   import stack_pkg::*;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int PC_W   = 10;
   localparam int AW     = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stack_engine_if #(.DATA_W(DATA_W), .PC_W(PC_W), .AW(AW)) bus ();

   stack_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] mstk[$];
   logic [31:0] dq[$];
   logic [9:0]  pq[$];
   logic        movf = 1'b0;
   logic        munf = 1'b0;
   logic [31:0] mdout = '0;
   logic [9:0]  mpc = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic [2:0] o, input logic [31:0] d, input logic [9:0] pc,
                       input logic e, input logic c, input logic r);
      logic [31:0] v;
      logic [9:0]  pcn;
      logic        exp_dv, exp_pl;
      if (r) begin
         mstk.delete();
         movf = 1'b0;
         munf = 1'b0;
      end else begin
         if (e && !(movf || munf)) begin
            if (o == OP_PUSH || o == OP_CALL) begin
               if (mstk.size() == DEPTH) begin
                  if (!c) movf = 1'b1;
               end else begin
                  pcn = pc + 10'd1;
                  mstk.push_back((o == OP_CALL) ? {22'b0, pcn} : d);
               end
            end else if (o == OP_POP || o == OP_PEEK || o == OP_RET) begin
               if (mstk.size() == 0) begin
                  if (!c) munf = 1'b1;
               end else begin
                  v = mstk[$];
                  if (o != OP_PEEK) void'(mstk.pop_back());
                  if (o == OP_RET) pq.push_back(v[9:0]);
                  else dq.push_back(v);
               end
            end
         end
         if (c) begin
            movf = 1'b0;
            munf = 1'b0;
         end
      end
      bus.op     = o;
      bus.din    = d;
      bus.pcIn   = pc;
      bus.en     = e;
      bus.clrErr = c;
      rst        = r;
      @(posedge clk);
      @(negedge clk);
      exp_dv = (dq.size() > 0);
      exp_pl = (pq.size() > 0);
      if (exp_dv) mdout = dq.pop_front();
      if (exp_pl) mpc = pq.pop_front();
      if (r) begin
         mdout = '0;
         mpc   = '0;
      end
      chk("doutValid", {31'b0, bus.doutValid}, {31'b0, exp_dv});
      chk("dout", bus.dout, mdout);
      chk("pcLoad", {31'b0, bus.pcLoad}, {31'b0, exp_pl});
      chk("pcOut", {22'b0, bus.pcOut}, {22'b0, mpc});
      chk("level", {29'b0, bus.level}, mstk.size());
      chk("full", {31'b0, bus.full}, {31'b0, mstk.size() == DEPTH});
      chk("empty", {31'b0, bus.empty}, {31'b0, mstk.size() == 0});
      chk("ovf", {31'b0, bus.ovf}, {31'b0, movf});
      chk("unf", {31'b0, bus.unf}, {31'b0, munf});
   endtask

   task automatic push(input logic [31:0] d);
      tick(OP_PUSH, d, '0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic op1(input logic [2:0] o);
      tick(o, '0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      bus.en = 1'b0; bus.op = '0; bus.din = '0; bus.pcIn = '0; bus.clrErr = 1'b0;
      rst = 1'b1;
      tick(OP_NOP, '0, '0, 1'b0, 1'b0, 1'b1);
      tick(OP_NOP, '0, '0, 1'b0, 1'b0, 1'b1);
      chk("rst_level", {29'b0, bus.level}, 32'd0);
      chk("rst_empty", {31'b0, bus.empty}, 32'd1);
      chk("rst_dout", bus.dout, 32'd0);

      push(32'hA5);
      push(32'h5A);
      op1(OP_POP);
      chk("pop1_dout", bus.dout, 32'h5A);
      op1(OP_POP);
      chk("pop2_dout", bus.dout, 32'hA5);
      chk("pop2_empty", {31'b0, bus.empty}, 32'd1);

      tick(OP_CALL, '0, 10'h3FF, 1'b1, 1'b0, 1'b0);
      chk("call_level", {29'b0, bus.level}, 32'd1);
      op1(OP_RET);
      chk("ret_pcload", {31'b0, bus.pcLoad}, 32'd1);
      chk("ret_pcout", {22'b0, bus.pcOut}, 32'd0);
      chk("ret_level", {29'b0, bus.level}, 32'd0);
      tick(OP_CALL, '0, 10'h123, 1'b1, 1'b0, 1'b0);
      op1(OP_RET);
      chk("ret2_pcout", {22'b0, bus.pcOut}, 32'h124);

      for (int i = 1; i <= 4; i++) push(32'(i));
      chk("fill_full", {31'b0, bus.full}, 32'd1);
      push(32'd5);
      chk("ovf_set", {31'b0, bus.ovf}, 32'd1);
      chk("ovf_level", {29'b0, bus.level}, 32'd4);
      op1(OP_POP);
      chk("frozen_pop", {31'b0, bus.doutValid}, 32'd0);
      tick(OP_NOP, '0, '0, 1'b0, 1'b1, 1'b0);
      chk("clr_ovf", {31'b0, bus.ovf}, 32'd0);
      op1(OP_POP);
      chk("after_clr_pop", bus.dout, 32'd4);
      for (int i = 0; i < 3; i++) op1(OP_POP);

      tick(OP_POP, '0, '0, 1'b1, 1'b1, 1'b0);
      chk("clr_priority", {31'b0, bus.unf}, 32'd0);

      op1(OP_POP);
      chk("unf_set", {31'b0, bus.unf}, 32'd1);
      push(32'h77);
      chk("unf_frozen", {29'b0, bus.level}, 32'd0);
      tick(OP_NOP, '0, '0, 1'b0, 1'b1, 1'b0);

      push(32'h11);
      op1(OP_PEEK);
      chk("peek1", bus.dout, 32'h11);
      op1(OP_PEEK);
      chk("peek2", bus.dout, 32'h11);
      chk("peek_level", {29'b0, bus.level}, 32'd1);
      tick(OP_POP, '0, '0, 1'b0, 1'b0, 1'b0);
      tick(3'd6, '0, '0, 1'b1, 1'b0, 1'b0);
      tick(3'd7, '0, '0, 1'b1, 1'b0, 1'b0);
      tick(OP_POP, '0, '0, 1'b1, 1'b0, 1'b1);
      chk("rst_pop_valid", {31'b0, bus.doutValid}, 32'd0);
      chk("rst_pop_level", {29'b0, bus.level}, 32'd0);

      push(32'h33);
      op1(OP_POP);
      tick(OP_NOP, '0, '0, 1'b0, 1'b0, 1'b1);
      chk("pre_rst_pulse", {31'b0, bus.doutValid}, 32'd0);

      for (int i = 0; i < 300; i++) begin
         tick(3'($urandom_range(0, 7)), $urandom, 10'($urandom_range(0, 1023)),
              $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 63) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/stack_engine.md
STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 Parameter DATA_W, 32, data word width in bits.
REQ-002 Parameter DEPTH, 2048, number of stack entries; SHALL be a power of two, minimum 4.
REQ-003 Parameter PC_W, 10, program-counter width for CALL/RET.
REQ-004 Derived constant AW = log2(DEPTH), the entry address width.
REQ-005 clk  in  1  single system clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en  in  1  qualifies op for the current cycle.
REQ-008 op  in  3  operation: NOP=0, PUSH=1, POP=2, PEEK=3, CALL=4, RET=5; codes 6-7 behave as NOP.
REQ-009 din  in  DATA_W  PUSH data.
REQ-010 pcIn  in  PC_W  current PC, sampled on CALL.
REQ-011 clrErr  in  1  clears the sticky error flags and unfreezes the stack.
REQ-012 dout  out  DATA_W  POP/PEEK result.
REQ-013 doutValid  out  1  one-cycle pulse marking dout updated.
REQ-014 pcOut  out  PC_W  return address from RET.
REQ-015 pcLoad  out  1  one-cycle pulse; program counter loads pcOut.
REQ-016 full, empty  out  1 each  combinational from level.
REQ-017 level  out  AW+1  current entry count, 0..DEPTH.
REQ-018 ovf, unf  out  1 each  sticky overflow and underflow flags.

Function
REQ-019 The stack SHALL grow upward; the internal pointer sp SHALL equal level and address the next free entry.
REQ-020 PUSH with !full SHALL write din to mem[sp] and increment level in the same edge.
REQ-021 CALL with !full SHALL write pcIn+1 (modulo 2^PC_W, zero-extended to DATA_W) to mem[sp] and increment level.
REQ-022 POP with !empty SHALL decrement level; dout SHALL hold mem[sp-1] with doutValid=1 exactly one cycle after the op cycle.
REQ-023 PEEK with !empty SHALL leave level unchanged; dout and doutValid SHALL follow the same timing as POP.
REQ-024 RET with !empty SHALL decrement level; pcOut SHALL hold mem[sp-1][PC_W-1:0] with pcLoad=1 one cycle after the op cycle; dout and doutValid SHALL be unaffected.
REQ-025 PUSH or CALL while full SHALL write nothing, leave level unchanged and set ovf.
REQ-026 POP, PEEK or RET while empty SHALL leave level unchanged, pulse neither doutValid nor pcLoad, and set unf.
REQ-027 While ovf or unf is set, the stack SHALL be frozen: all ops are ignored, and no further flag changes occur except by clrErr or rst.
REQ-028 clrErr SHALL clear ovf and unf at the next edge, SHALL NOT alter level or memory, and SHALL take priority over an op that would set a flag in the same cycle (that op is then ignored).
REQ-029 A back-to-back PUSH then POP SHALL return the just-pushed value; the cycle after a PUSH SHALL see no read-after-write hazard.
REQ-030 dout and pcOut SHALL hold their last value between valid pulses.
REQ-031 en=0 SHALL be equivalent to NOP.
REQ-032 Level arithmetic SHALL never wrap: level never exceeds DEPTH and never falls below 0.

Reset
REQ-033 On rst: level=0, ovf=0, unf=0, dout=0, pcOut=0, doutValid=0, pcLoad=0, empty=1, full=0.
REQ-034 Memory contents SHALL NOT require reset.
REQ-035 rst SHALL override every other input in the same cycle.
REQ-036 A POP or RET issued in the cycle before rst SHALL NOT produce a pulse after rst.

Structure
REQ-037 The op encodings and the AW derivation SHALL live in shared package stack_pkg.
REQ-038 Storage SHALL be one sub-module, stack_ram, with one synchronous write port and one synchronous read port of DEPTH x DATA_W.
REQ-039 The read address SHALL be sp-1, giving the one-cycle read latency of REQ-022.

Verification
REQ-040 Reset, then PUSH 0xA5, 0x5A, then POP, POP -> dout=0x5A, then 0x5A5 is not involved: dout=0x5A followed by dout=0xA5, each with doutValid one cycle after its POP; empty=1 at the end.
REQ-041 CALL with pcIn=0x3FF, then RET -> pcOut=0x000 (wrap), pcLoad pulses one cycle after RET, level returns to 0.
REQ-042 DEPTH=4: five PUSHes -> full=1 after the fourth, ovf=1 after the fifth, level=4; a following POP is ignored; clrErr, then POP -> returns the fourth value pushed.
REQ-043 POP on an empty stack -> unf=1, no doutValid pulse; a subsequent PUSH is ignored until clrErr.
REQ-044 PUSH 0x11, then PEEK twice -> dout=0x11 twice and level=1; rst asserted during a POP -> no doutValid pulse and level=0.
